ly_input_cond: RTL and testbench

Per-layer input conditioner for one 32-channel anode layer. It sits directly upstream of the layer one-shot stage and drives that stage's 32-bit `ly` input. It synchronises raw comparator hits to the trigger clock, applies a programmable delay of 0–15 clocks, and applies the hot-channel mask. It also detects and auto-masks channels stuck high.

---
 rtl/alct_ly_pkg.sv | 12 +
 rtl/ly_chan_cond.sv | 78 +++++++
 rtl/ly_input_cond.sv | 57 +++++
 tb/tb_ly_input_cond.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alct_ly_pkg.sv
// Shared layer-level types and dimensions for the anode-layer input path.
// Also used by the layer one-shot stage.
package alct_ly_pkg;

  localparam int NCH       = 32;
  localparam int DLY_W     = 4;
  localparam int STK_W     = 8;
  localparam int DLY_DEPTH = 1 << DLY_W;

  typedef logic [NCH-1:0] ly_t;

endpackage

// File: rtl/ly_chan_cond.sv
// One-channel conditioner: two-flop synchroniser, programmable delay line with
// tap mux, and a saturating stuck-high detector with a sticky flag.
module ly_chan_cond
  import alct_ly_pkg::*;
#(
  parameter int DLY_BITS = DLY_W,
  parameter int CNT_BITS = STK_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw,
  input  logic [DLY_BITS-1:0] dly,
  input  logic [CNT_BITS-1:0] stuck_limit,
  input  logic                stuck_clr,
  output logic                tap,
  output logic                stuck
);

  localparam int DEPTH = 1 << DLY_BITS;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};
  localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic                s1_r;
  logic                s2_r;
  logic [DEPTH-1:0]    dl_r;
  logic [CNT_BITS-1:0] cnt_r;
  logic                stuck_r;
  logic                set_s;

  // s1 is only ever copied into s2; everything downstream sees s2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      dl_r <= {DEPTH{1'b0}};
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
      dl_r <= {dl_r[DEPTH-2:0], s2_r};
    end
  end

  assign tap = dl_r[dly];

  // flag sets on the stuck_limit-th consecutive high sample; limit 0 disables
  always_comb begin
    set_s = 1'b0;
    if (stuck_limit != CNT_ZERO) begin
      set_s = s2_r && (cnt_r == (stuck_limit - CNT_ONE));
    end else begin
      set_s = 1'b0;
    end
  end

  // counter saturates at the limit; clear has priority over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst || stuck_clr) begin
      cnt_r   <= CNT_ZERO;
      stuck_r <= 1'b0;
    end else begin
      if (!s2_r || (stuck_limit == CNT_ZERO)) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r < stuck_limit) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (set_s) begin
        stuck_r <= 1'b1;
      end else begin
        stuck_r <= stuck_r;
      end
    end
  end

  assign stuck = stuck_r;

endmodule

// File: rtl/ly_input_cond.sv
// Per-layer input conditioner: per-channel sync/delay/stuck detection, then a
// registered output gate applying the hot-channel mask and stuck suppression.
module ly_input_cond #(
  parameter int NCH   = alct_ly_pkg::NCH,
  parameter int DLY_W = alct_ly_pkg::DLY_W,
  parameter int STK_W = alct_ly_pkg::STK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   ly_raw,
  input  logic [NCH-1:0]   hot_mask,
  input  logic [DLY_W-1:0] dly,
  input  logic [STK_W-1:0] stuck_limit,
  input  logic             stuck_en,
  input  logic             stuck_clr,
  output logic [NCH-1:0]   ly,
  output logic [NCH-1:0]   stuck,
  output logic             stuck_any
);

  logic [NCH-1:0] tap_s;
  logic [NCH-1:0] stuck_s;
  logic [NCH-1:0] ly_r;
  logic           stuck_any_r;

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    ly_chan_cond #(
      .DLY_BITS (DLY_W),
      .CNT_BITS (STK_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .raw         (ly_raw[ch]),
      .dly         (dly),
      .stuck_limit (stuck_limit),
      .stuck_clr   (stuck_clr),
      .tap         (tap_s[ch]),
      .stuck       (stuck_s[ch])
    );
  end

  // masks act only here, so detection always runs on unmasked data
  always_ff @(posedge clk) begin
    if (rst) begin
      ly_r        <= {NCH{1'b0}};
      stuck_any_r <= 1'b0;
    end else begin
      ly_r        <= tap_s & hot_mask & ~(stuck_s & {NCH{stuck_en}});
      stuck_any_r <= |stuck_s;
    end
  end

  assign ly        = ly_r;
  assign stuck     = stuck_s;
  assign stuck_any = stuck_any_r;

endmodule

// File: tb/tb_ly_input_cond.sv
// Directed bench for ly_input_cond: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived from the pipeline timing.
module tb_ly_input_cond;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ly_raw;
  logic [31:0] hot_mask;
  logic [3:0]  dly;
  logic [7:0]  stuck_limit;
  logic        stuck_en;
  logic        stuck_clr;
  logic [31:0] ly;
  logic [31:0] stuck;
  logic        stuck_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ly_input_cond dut (
    .clk         (clk),
    .rst         (rst),
    .ly_raw      (ly_raw),
    .hot_mask    (hot_mask),
    .dly         (dly),
    .stuck_limit (stuck_limit),
    .stuck_en    (stuck_en),
    .stuck_clr   (stuck_clr),
    .ly          (ly),
    .stuck       (stuck),
    .stuck_any   (stuck_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold raw at zero long enough to empty the whole delay line under a new tap.
  task automatic flush(input logic [3:0] d);
    ly_raw = 32'h0;
    dly    = d;
    repeat (20) @(negedge clk);
    check("flush_ly", ly, 32'h0);
  endtask

  // Drive a width-clock pulse and check ly on every falling edge afterwards.
  task automatic run_pulse(input logic [31:0] bits, input int width, input int lat,
                           input logic [31:0] exp_bits, input string tag);
    logic [31:0] exp;
    for (int t = 0; t < lat + width + 3; t++) begin
      ly_raw = (t < width) ? bits : 32'h0;
      @(negedge clk);
      exp = ((t + 1 >= lat) && (t + 1 < lat + width)) ? exp_bits : 32'h0;
      check(tag, ly, exp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    ly_raw      = 32'hFFFF_FFFF;
    hot_mask    = 32'hFFFF_FFFF;
    dly         = 4'd0;
    stuck_limit = 8'd0;
    stuck_en    = 1'b0;
    stuck_clr   = 1'b0;

    // reset held with all inputs high
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("rst_ly", ly, 32'h0);
      check("rst_stuck", stuck, 32'h0);
      check("rst_any", {31'b0, stuck_any}, 32'h0);
    end
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      check("release_ly", ly, (t >= 4) ? 32'hFFFF_FFFF : 32'h0);
    end

    // latency sweep on bit 5
    flush(4'd0);
    run_pulse(32'h0000_0020, 1, 4, 32'h0000_0020, "lat_dly0");
    flush(4'd7);
    run_pulse(32'h0000_0020, 1, 11, 32'h0000_0020, "lat_dly7");
    flush(4'd15);
    run_pulse(32'h0000_0020, 1, 19, 32'h0000_0020, "lat_dly15");

    // hot mask disables bit 0
    flush(4'd0);
    hot_mask = 32'hFFFF_FFFE;
    @(negedge clk);
    run_pulse(32'h0000_0003, 1, 4, 32'h0000_0002, "mask_w1");
    run_pulse(32'h0000_0003, 3, 4, 32'h0000_0002, "mask_w3");
    hot_mask = 32'hFFFF_FFFF;

    // a 9-clock run never reaches a limit of 10
    stuck_limit = 8'd10;
    stuck_en    = 1'b1;
    run_pulse(32'h8000_0000, 9, 4, 32'h8000_0000, "run9_ly");
    check("run9_stuck", stuck, 32'h0);
    check("run9_any", {31'b0, stuck_any}, 32'h0);

    // bit 31 held high: flag after the 10th sample, then ly suppressed
    ly_raw = 32'h8000_0000;
    for (int t = 1; t <= 14; t++) begin
      @(negedge clk);
      check("stk_flag", stuck, (t >= 12) ? 32'h8000_0000 : 32'h0);
      check("stk_any", {31'b0, stuck_any}, (t >= 13) ? 32'h1 : 32'h0);
      check("stk_ly", ly, ((t >= 4) && (t < 13)) ? 32'h8000_0000 : 32'h0);
    end

    // clear now, and clear again exactly when the flag would re-set
    stuck_clr = 1'b1;
    for (int t = 1; t <= 22; t++) begin
      @(negedge clk);
      stuck_clr = (t == 10);
      check("clr_flag", stuck, (t >= 21) ? 32'h8000_0000 : 32'h0);
      check("clr_any", {31'b0, stuck_any}, ((t == 1) || (t == 22)) ? 32'h1 : 32'h0);
    end
    check("clr_ly_sup", ly, 32'h0);

    // stuck_en off lets the flagged channel through again
    stuck_en = 1'b0;
    @(negedge clk);
    check("en0_ly", ly, 32'h8000_0000);
    stuck_en = 1'b1;
    @(negedge clk);
    check("en1_ly", ly, 32'h0);

    // limit 0: a long high run sets nothing, existing flag retained
    stuck_en    = 1'b0;
    stuck_limit = 8'd0;
    ly_raw      = 32'h4000_0000;
    repeat (300) @(negedge clk);
    check("dis_stuck", stuck, 32'h8000_0000);
    check("dis_any", {31'b0, stuck_any}, 32'h1);
    check("dis_ly", ly, 32'h4000_0000);

    // reset mid-operation clears everything
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ly", ly, 32'h0);
    check("mid_rst_stuck", stuck, 32'h0);
    check("mid_rst_any", {31'b0, stuck_any}, 32'h0);
    rst = 1'b0;

    // a pulse in flight across a reset never reaches ly
    flush(4'd7);
    ly_raw = 32'h0000_0020;
    @(negedge clk);
    ly_raw = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      check("straddle_ly", ly, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
